// File: rtl/pmem_arbiter_if.sv
// Shared physical-memory port bundle between I-cache, D-cache, the arbiter
// and the physical memory model.
//   slave  : arbiter side (consumes cache requests and memory replies)
//   master : environment side (caches and memory drive requests/replies)
// Signals:
//   icache_pmem_* / dcache_pmem_* : per-cache 128-bit line interfaces
//   pmem_*                        : arbitrated physical-memory port
//   grant_i / grant_d             : current owner of the memory port
interface pmem_arbiter_if #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned LINE_W = 128
);

  logic              icache_pmem_read;
  logic              icache_pmem_write;
  logic [ADDR_W-1:0] icache_pmem_address;
  logic [LINE_W-1:0] icache_pmem_wdata;
  logic              icache_pmem_resp;
  logic [LINE_W-1:0] icache_pmem_rdata;

  logic              dcache_pmem_read;
  logic              dcache_pmem_write;
  logic [ADDR_W-1:0] dcache_pmem_address;
  logic [LINE_W-1:0] dcache_pmem_wdata;
  logic              dcache_pmem_resp;
  logic [LINE_W-1:0] dcache_pmem_rdata;

  logic              pmem_read;
  logic              pmem_write;
  logic [ADDR_W-1:0] pmem_address;
  logic [LINE_W-1:0] pmem_wdata;
  logic              pmem_resp;
  logic [LINE_W-1:0] pmem_rdata;

  logic              grant_i;
  logic              grant_d;

  modport slave (
    input  icache_pmem_read, icache_pmem_write, icache_pmem_address, icache_pmem_wdata,
    output icache_pmem_resp, icache_pmem_rdata,
    input  dcache_pmem_read, dcache_pmem_write, dcache_pmem_address, dcache_pmem_wdata,
    output dcache_pmem_resp, dcache_pmem_rdata,
    output pmem_read, pmem_write, pmem_address, pmem_wdata,
    input  pmem_resp, pmem_rdata,
    output grant_i, grant_d
  );

  modport master (
    output icache_pmem_read, icache_pmem_write, icache_pmem_address, icache_pmem_wdata,
    input  icache_pmem_resp, icache_pmem_rdata,
    output dcache_pmem_read, dcache_pmem_write, dcache_pmem_address, dcache_pmem_wdata,
    input  dcache_pmem_resp, dcache_pmem_rdata,
    input  pmem_read, pmem_write, pmem_address, pmem_wdata,
    output pmem_resp, pmem_rdata,
    input  grant_i, grant_d
  );

endinterface

// File: rtl/pmem_arbiter.sv
// Two-port arbiter sharing one physical-memory port between the I-cache and
// the D-cache. One cache owns the port from grant until pmem_resp; a one-cycle
// RELEASE state follows every transaction so the served cache can drop its
// request before the next arbitration. Ties are broken round-robin.
// Ports:
//   clk     : clock, rising edge
//   reset_n : asynchronous active-low reset
//   bus     : pmem_arbiter_if.slave (cache line interfaces, memory port, grants)
module pmem_arbiter #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned LINE_W = 128
) (
  input  logic          clk,
  input  logic          reset_n,
  pmem_arbiter_if.slave bus
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_SERVE_I = 2'd1;
  localparam logic [1:0] ST_SERVE_D = 2'd2;
  localparam logic [1:0] ST_RELEASE = 2'd3;

  localparam logic GNT_I = 1'b0;
  localparam logic GNT_D = 1'b1;

  logic [1:0] state_q;
  logic [1:0] state_d;
  logic       last_grant_q;
  logic       last_grant_d;
  logic       req_i;
  logic       req_d;

  assign req_i = bus.icache_pmem_read | bus.icache_pmem_write;
  assign req_d = bus.dcache_pmem_read | bus.dcache_pmem_write;

  // State and round-robin history registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      last_grant_q <= GNT_I;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
    end
  end

  // Next-state decode and memory-port mux, both keyed on the current state
  always_comb begin
    state_d              = state_q;
    last_grant_d         = last_grant_q;
    bus.pmem_read        = 1'b0;
    bus.pmem_write       = 1'b0;
    bus.pmem_address     = ADDR_W'(0);
    bus.pmem_wdata       = LINE_W'(0);
    bus.icache_pmem_resp = 1'b0;
    bus.dcache_pmem_resp = 1'b0;
    bus.grant_i          = 1'b0;
    bus.grant_d          = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // D wins when alone, or on a tie when I was served last
        if (req_d && (!req_i || (last_grant_q == GNT_I))) begin
          state_d      = ST_SERVE_D;
          last_grant_d = GNT_D;
        end else if (req_i) begin
          state_d      = ST_SERVE_I;
          last_grant_d = GNT_I;
        end
      end

      ST_SERVE_I: begin
        bus.grant_i          = 1'b1;
        bus.pmem_read        = bus.icache_pmem_read;
        bus.pmem_write       = bus.icache_pmem_write;
        bus.pmem_address     = bus.icache_pmem_address;
        bus.pmem_wdata       = bus.icache_pmem_wdata;
        bus.icache_pmem_resp = bus.pmem_resp;
        if (bus.pmem_resp) begin
          state_d = ST_RELEASE;
        end
      end

      ST_SERVE_D: begin
        bus.grant_d          = 1'b1;
        bus.pmem_read        = bus.dcache_pmem_read;
        bus.pmem_write       = bus.dcache_pmem_write;
        bus.pmem_address     = bus.dcache_pmem_address;
        bus.pmem_wdata       = bus.dcache_pmem_wdata;
        bus.dcache_pmem_resp = bus.pmem_resp;
        if (bus.pmem_resp) begin
          state_d = ST_RELEASE;
        end
      end

      ST_RELEASE: begin
        // Dead cycle: the served cache's stale request must not be re-granted
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Read data is broadcast; only the response strobe selects the consumer
  assign bus.icache_pmem_rdata = bus.pmem_rdata;
  assign bus.dcache_pmem_rdata = bus.pmem_rdata;

  // The two grants must never be active together
  a_grant_onehot: assert property (@(posedge clk) disable iff (!reset_n)
    !(bus.grant_i && bus.grant_d));

  // A response strobe reaches at most one cache
  a_resp_onehot: assert property (@(posedge clk) disable iff (!reset_n)
    !(bus.icache_pmem_resp && bus.dcache_pmem_resp));

endmodule

// File: tb/tb_pmem_arbiter.sv
// Scoreboard bench for pmem_arbiter: cache drivers issue line requests, a
// memory model answers after a programmable latency, and a monitor pops the
// hand-computed expected response on every resp strobe.
module tb_pmem_arbiter;

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned LINE_W = 128;

  localparam logic [127:0] RST_RD  = 128'hC0FFEE00_11112222_33334444_5555AAAA;
  localparam logic [127:0] SPUR_RD = 128'h55555555_55555555_55555555_55555555;
  localparam logic [127:0] BEEF_RD = 128'hDEAD0123_456789AB_CDEF0011_2233BEEF;
  localparam logic [127:0] RD_4000 = 128'hE5A5E5A5_E5A5E5A5_E5A5E5A5_E5A5E5A5;
  localparam logic [127:0] RD_0100 = 128'hA4A5A4A5_A4A5A4A5_A4A5A4A5_A4A5A4A5;
  localparam logic [127:0] RD_0300 = 128'hA6A5A6A5_A6A5A6A5_A6A5A6A5_A6A5A6A5;
  localparam logic [127:0] WD_1    = 128'h01020304_05060708_090A0B0C_0D0E0F10;
  localparam logic [127:0] WD_2    = 128'hF0E0D0C0_B0A09080_70605040_30201000;

  typedef struct {
    logic [15:0]  addr;
    bit           wr;
    logic [127:0] wdata;
  } req_t;

  typedef struct {
    bit           is_d;
    logic [15:0]  addr;
    bit           wr;
    logic [127:0] wdata;
    logic [127:0] rdata;
  } exp_t;

  logic clk;
  logic reset_n;

  pmem_arbiter_if #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) bus ();

  pmem_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  req_t iq[$];
  req_t dq[$];
  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  bit   i_busy = 0;
  bit   d_busy = 0;
  bit   abort_d = 0;
  int   lat = 3;
  bit   spur_arm = 0;
  bit   spur_ack = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic expect_resp(input bit is_d, input logic [15:0] a, input bit wr,
                             input logic [127:0] wd, input logic [127:0] rd);
    exp_t e;
    e.is_d = is_d; e.addr = a; e.wr = wr; e.wdata = wd; e.rdata = rd;
    exp_q.push_back(e);
  endtask

  task automatic issue(input bit is_d, input logic [15:0] a, input bit wr, input logic [127:0] wd);
    req_t r;
    r.addr = a; r.wr = wr; r.wdata = wd;
    if (is_d) dq.push_back(r);
    else      iq.push_back(r);
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((iq.size() != 0 || dq.size() != 0 || i_busy || d_busy || exp_q.size() != 0) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) begin
      total++; bad++;
      $display("FAIL drain_timeout: pending exp=%0d", exp_q.size());
    end
    repeat (3) @(negedge clk);
  endtask

  function automatic logic [127:0] mem_line(input logic [15:0] a);
    if (a == 16'h1230) return BEEF_RD;
    return {8{a ^ 16'hA5A5}};
  endfunction

  // Physical memory model: answers a held request after lat cycles
  initial begin : mem_model
    int cnt;
    cnt = 0;
    bus.pmem_resp  = 1'b0;
    bus.pmem_rdata = RST_RD;
    forever begin
      @(posedge clk); #1;
      if (bus.pmem_resp) begin
        bus.pmem_resp = 1'b0;
        cnt = 0;
      end else if (spur_arm != spur_ack) begin
        spur_ack       = spur_arm;
        bus.pmem_resp  = 1'b1;
        bus.pmem_rdata = SPUR_RD;
      end else if (bus.pmem_read || bus.pmem_write) begin
        cnt++;
        if (cnt >= lat) begin
          bus.pmem_resp  = 1'b1;
          bus.pmem_rdata = mem_line(bus.pmem_address);
        end
      end else begin
        cnt = 0;
      end
    end
  end

  // I-cache driver: holds each request until its resp
  initial begin : drv_icache
    req_t r;
    int   n;
    bus.icache_pmem_read    = 1'b0;
    bus.icache_pmem_write   = 1'b0;
    bus.icache_pmem_address = '0;
    bus.icache_pmem_wdata   = '0;
    forever begin
      @(posedge clk); #1;
      if (iq.size() == 0) begin
        bus.icache_pmem_read  = 1'b0;
        bus.icache_pmem_write = 1'b0;
      end else begin
        r = iq.pop_front();
        i_busy = 1;
        bus.icache_pmem_read    = !r.wr;
        bus.icache_pmem_write   = r.wr;
        bus.icache_pmem_address = r.addr;
        bus.icache_pmem_wdata   = r.wdata;
        n = 0;
        do begin @(negedge clk); n++; end while (!bus.icache_pmem_resp && n < 500);
        if (!bus.icache_pmem_resp) begin
          total++; bad++;
          $display("FAIL icache_resp_timeout: addr %h", r.addr);
        end
        i_busy = 0;
      end
    end
  end

  // D-cache driver: same, plus an abort path for the reset-mid-transaction case
  initial begin : drv_dcache
    req_t r;
    int   n;
    bus.dcache_pmem_read    = 1'b0;
    bus.dcache_pmem_write   = 1'b0;
    bus.dcache_pmem_address = '0;
    bus.dcache_pmem_wdata   = '0;
    forever begin
      @(posedge clk); #1;
      if (dq.size() == 0) begin
        bus.dcache_pmem_read  = 1'b0;
        bus.dcache_pmem_write = 1'b0;
      end else begin
        r = dq.pop_front();
        d_busy = 1;
        bus.dcache_pmem_read    = !r.wr;
        bus.dcache_pmem_write   = r.wr;
        bus.dcache_pmem_address = r.addr;
        bus.dcache_pmem_wdata   = r.wdata;
        n = 0;
        do begin @(negedge clk); n++; end while (!bus.dcache_pmem_resp && !abort_d && n < 500);
        if (!bus.dcache_pmem_resp && !abort_d) begin
          total++; bad++;
          $display("FAIL dcache_resp_timeout: addr %h", r.addr);
        end
        d_busy = 0;
      end
    end
  end

  // Monitor: every resp strobe must match the next scoreboard entry
  always @(negedge clk) begin : monitor
    exp_t e;
    if (bus.icache_pmem_resp || bus.dcache_pmem_resp) begin
      check("resp_both", 128'(bus.icache_pmem_resp && bus.dcache_pmem_resp), 128'd0);
      if (exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_resp: i=%0b d=%0b addr %h", bus.icache_pmem_resp,
                 bus.dcache_pmem_resp, bus.pmem_address);
      end else begin
        e = exp_q.pop_front();
        check("resp_port_d", 128'(bus.dcache_pmem_resp), 128'(e.is_d));
        check("resp_grant_d", 128'(bus.grant_d), 128'(e.is_d));
        check("resp_addr", 128'(bus.pmem_address), 128'(e.addr));
        check("resp_write", 128'(bus.pmem_write), 128'(e.wr));
        check("resp_read", 128'(bus.pmem_read), 128'(!e.wr));
        if (e.wr) check("resp_wdata", bus.pmem_wdata, e.wdata);
        check("resp_rdata_i", bus.icache_pmem_rdata, e.rdata);
        check("resp_rdata_d", bus.dcache_pmem_rdata, e.rdata);
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int n;
    int gap;
    int stable_bad;

    // Reset with both caches requesting
    reset_n = 1'b0;
    issue(1'b1, 16'h4000, 1'b1, WD_1);
    issue(1'b0, 16'h0100, 1'b0, '0);
    expect_resp(1'b1, 16'h4000, 1'b1, WD_1, RD_4000);
    expect_resp(1'b0, 16'h0100, 1'b0, '0, RD_0100);
    repeat (3) @(negedge clk);
    check("rst_pmem_read", 128'(bus.pmem_read), 128'd0);
    check("rst_pmem_write", 128'(bus.pmem_write), 128'd0);
    check("rst_pmem_address", 128'(bus.pmem_address), 128'd0);
    check("rst_pmem_wdata", bus.pmem_wdata, 128'd0);
    check("rst_resp_i", 128'(bus.icache_pmem_resp), 128'd0);
    check("rst_resp_d", 128'(bus.dcache_pmem_resp), 128'd0);
    check("rst_grant_i", 128'(bus.grant_i), 128'd0);
    check("rst_grant_d", 128'(bus.grant_d), 128'd0);
    check("rst_rdata_i", bus.icache_pmem_rdata, RST_RD);
    check("rst_rdata_d", bus.dcache_pmem_rdata, RST_RD);
    reset_n = 1'b1;
    @(negedge clk);
    check("rel_grant_d", 128'(bus.grant_d), 128'd1);
    check("rel_grant_i", 128'(bus.grant_i), 128'd0);
    check("rel_pmem_write", 128'(bus.pmem_write), 128'd1);
    check("rel_pmem_address", 128'(bus.pmem_address), 128'h4000);
    wait_drain();

    // Lone I read with one-cycle-after-request grant
    issue(1'b0, 16'h1230, 1'b0, '0);
    expect_resp(1'b0, 16'h1230, 1'b0, '0, BEEF_RD);
    n = 0;
    while (!bus.grant_i && n < 20) begin @(negedge clk); n++; end
    check("lone_grant_cycles", 128'(n), 128'd2);
    check("lone_pmem_address", 128'(bus.pmem_address), 128'h1230);
    check("lone_pmem_read", 128'(bus.pmem_read), 128'd1);
    check("lone_resp_d", 128'(bus.dcache_pmem_resp), 128'd0);
    wait_drain();

    // Both caches requesting continuously: D, I, D, I with 2 dead cycles
    issue(1'b1, 16'h4000, 1'b1, WD_2);
    issue(1'b1, 16'h4000, 1'b1, WD_2);
    issue(1'b0, 16'h0100, 1'b0, '0);
    issue(1'b0, 16'h0100, 1'b0, '0);
    expect_resp(1'b1, 16'h4000, 1'b1, WD_2, RD_4000);
    expect_resp(1'b0, 16'h0100, 1'b0, '0, RD_0100);
    expect_resp(1'b1, 16'h4000, 1'b1, WD_2, RD_4000);
    expect_resp(1'b0, 16'h0100, 1'b0, '0, RD_0100);
    for (int k = 0; k < 3; k++) begin
      n = 0;
      while (!(bus.icache_pmem_resp || bus.dcache_pmem_resp) && n < 200) begin @(negedge clk); n++; end
      gap = 0;
      @(negedge clk);
      while (!(bus.grant_i || bus.grant_d) && gap < 50) begin gap++; @(negedge clk); end
      check("alt_dead_cycles", 128'(gap), 128'd2);
    end
    wait_drain();

    // D arrives while I is being served
    issue(1'b0, 16'h0100, 1'b0, '0);
    expect_resp(1'b0, 16'h0100, 1'b0, '0, RD_0100);
    expect_resp(1'b1, 16'h4000, 1'b1, WD_2, RD_4000);
    n = 0;
    while (!bus.grant_i && n < 20) begin @(negedge clk); n++; end
    issue(1'b1, 16'h4000, 1'b1, WD_2);
    stable_bad = 0;
    n = 0;
    while (bus.grant_i && n < 50) begin
      if (bus.pmem_address !== 16'h0100 || bus.grant_d) stable_bad++;
      @(negedge clk);
      n++;
    end
    check("wait_addr_stable", 128'(stable_bad), 128'd0);
    check("wait_serve_len", 128'(n), 128'd3);
    wait_drain();

    // Spurious memory response while idle
    spur_arm = ~spur_arm;
    @(negedge clk);
    check("spur_resp_i", 128'(bus.icache_pmem_resp), 128'd0);
    check("spur_resp_d", 128'(bus.dcache_pmem_resp), 128'd0);
    check("spur_grant", 128'({bus.grant_i, bus.grant_d}), 128'd0);
    check("spur_rdata_bcast", bus.icache_pmem_rdata, SPUR_RD);
    @(negedge clk);
    check("spur_after_grant", 128'({bus.grant_i, bus.grant_d}), 128'd0);
    check("spur_after_read", 128'(bus.pmem_read), 128'd0);

    // Reset in the middle of a D transaction, then a lone I request
    lat = 20;
    issue(1'b1, 16'h2000, 1'b0, '0);
    n = 0;
    while (!bus.grant_d && n < 20) begin @(negedge clk); n++; end
    check("abort_grant_d", 128'(bus.grant_d), 128'd1);
    #2;
    reset_n = 1'b0;
    abort_d = 1'b1;
    #1;
    check("abort_pmem_read", 128'(bus.pmem_read), 128'd0);
    check("abort_grant_d_low", 128'(bus.grant_d), 128'd0);
    check("abort_pmem_address", 128'(bus.pmem_address), 128'd0);
    repeat (3) @(negedge clk);
    lat = 3;
    issue(1'b0, 16'h0300, 1'b0, '0);
    expect_resp(1'b0, 16'h0300, 1'b0, '0, RD_0300);
    @(negedge clk);
    reset_n = 1'b1;
    abort_d = 1'b0;
    @(negedge clk);
    check("post_rst_grant_i", 128'(bus.grant_i), 128'd1);
    check("post_rst_grant_d", 128'(bus.grant_d), 128'd0);
    wait_drain();

    check("scoreboard_empty", 128'(exp_q.size()), 128'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
